// File: rtl/axis_sink_checker_if.sv
// AXI4-Stream bundle for axis_sink_checker: master drives the beat, slave returns tready.
interface axis_sink_checker_if #(
  parameter int DATA_W = 32
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tid;
  logic                tdest;
  logic                tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_sink_checker.sv
// AXI4-Stream sink with rotating backpressure, incrementing-data and packet-length checks.
// Define AXIS_SINK_PROTO_CHECK_EN to add the valid/payload-stability-under-stall checker.
module axis_sink_checker #(
  parameter int          DATA_W        = 32,
  parameter logic [15:0] READY_PATTERN = 16'hFFFF,
  parameter int unsigned MAX_PKT_LEN   = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  axis_sink_checker_if.slave        axis,
  input  logic                      clr_stats,
  output logic [31:0]               beat_count,
  output logic [15:0]               pkt_count,
  output logic [15:0]               last_pkt_len,
  output logic                      data_err,
  output logic                      len_err,
  output logic                      proto_err,
  output logic [7:0]                err_count,
  output logic                      busy
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_PKT_LEN);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t            state;
  logic [15:0]       pattern;
  logic              ready_q;
  logic [DATA_W-1:0] exp_data;
  logic [15:0]       pkt_len;
  logic              len_hit;

  logic              hs;
  logic [16:0]       len_inc;
  logic [15:0]       len_sat;
  logic              data_ev;
  logic              len_ev;
  logic              proto_ev;
  logic              any_ev;
  logic [7:0]        err_base;

  logic              unused_sidebands;
  assign unused_sidebands = ^{axis.tstrb, axis.tkeep, axis.tid, axis.tdest, axis.tuser};

  assign axis.tready = ready_q;

  // Length is evaluated one bit wider so a saturated counter still reads as over-limit.
  always_comb begin
    hs       = axis.tvalid & ready_q;
    len_inc  = {1'b0, pkt_len} + 17'd1;
    len_sat  = (pkt_len == 16'hFFFF) ? 16'hFFFF : len_inc[15:0];
    data_ev  = hs && (axis.tdata != exp_data);
    len_ev   = hs && !len_hit && (len_inc > MAX_LEN);
    any_ev   = data_ev | len_ev | proto_ev;
    err_base = clr_stats ? '0 : err_count;
  end

  // Backpressure pattern and packet-tracking FSM; clr_stats never touches these.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pattern  <= READY_PATTERN;
      ready_q  <= 1'b0;
      exp_data <= '0;
      state    <= IDLE;
      busy     <= 1'b0;
      pkt_len  <= '0;
      len_hit  <= 1'b0;
    end else begin
      pattern <= {pattern[0], pattern[15:1]};
      ready_q <= pattern[1];
      if (hs) begin
        exp_data <= axis.tdata + DATA_W'(1);
        if (axis.tlast) begin
          state   <= IDLE;
          busy    <= 1'b0;
          pkt_len <= '0;
          len_hit <= 1'b0;
        end else begin
          state   <= IN_PKT;
          busy    <= 1'b1;
          pkt_len <= len_sat;
          len_hit <= len_hit | len_ev;
        end
      end
    end
  end

  // Statistics: a clear zeroes the base value, events of the same cycle land on top of it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_count   <= '0;
      pkt_count    <= '0;
      last_pkt_len <= '0;
      data_err     <= 1'b0;
      len_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      beat_count <= (clr_stats ? '0 : beat_count) + 32'(hs);
      pkt_count  <= (clr_stats ? '0 : pkt_count) + 16'(hs && axis.tlast);
      if (hs && axis.tlast) begin
        last_pkt_len <= len_sat;
      end else if (clr_stats) begin
        last_pkt_len <= '0;
      end
      data_err  <= (data_err & ~clr_stats) | data_ev;
      len_err   <= (len_err & ~clr_stats) | len_ev;
      err_count <= err_base + 8'(any_ev && (err_base != 8'hFF));
    end
  end

`ifdef AXIS_SINK_PROTO_CHECK_EN
  logic              stall_q;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  // A stalled beat must stay valid with unchanged payload on the following cycle.
  assign proto_ev = stall_q &&
                    (!axis.tvalid || (axis.tdata != hold_data) || (axis.tlast != hold_last));

  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_q   <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      stall_q   <= axis.tvalid & ~ready_q;
      hold_data <= axis.tdata;
      hold_last <= axis.tlast;
      proto_err <= (proto_err & ~clr_stats) | proto_ev;
    end
  end
`else
  assign proto_ev  = 1'b0;
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_sink_checker.sv
// Scoreboard bench for axis_sink_checker: four instances with different backpressure/length settings.
module tb_axis_sink_checker;

  typedef struct packed {
    logic [31:0] beats;
    logic [15:0] pkts;
    logic [15:0] last;
    logic        derr;
    logic        lerr;
    logic        perr;
    logic [7:0]  errc;
    logic        busy;
  } snap_t;

  localparam logic [15:0] PAT  [4] = '{16'hFFFF, 16'h5555, 16'hFFFF, 16'hFFFE};
  localparam int          MAXL [4] = '{256, 256, 4, 256};

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        clr = 1'b0;
  logic        tv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] td = '0;
  logic        tl = 1'b0;

  logic        rdy [4];
  logic [31:0] bc [4];
  logic [15:0] pc [4];
  logic [15:0] ll [4];
  logic        de [4];
  logic        le [4];
  logic        pe [4];
  logic [7:0]  ec [4];
  logic        bz [4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  snap_t sb [$];

  logic [31:0] m_beats, m_exp;
  logic [15:0] m_pkts, m_last;
  logic        m_derr, m_lerr, m_busy, m_hit;
  logic [7:0]  m_errc;
  int          m_plen;

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= areset ? 0 : cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    axis_sink_checker_if #(.DATA_W(32)) bus ();
    assign bus.tvalid = tv[g];
    assign bus.tdata  = td;
    assign bus.tlast  = tl;
    assign bus.tstrb  = '1;
    assign bus.tkeep  = '1;
    assign bus.tid    = 1'b0;
    assign bus.tdest  = 1'b0;
    assign bus.tuser  = 1'b0;
    assign rdy[g]     = bus.tready;

    axis_sink_checker #(
      .DATA_W(32),
      .READY_PATTERN(PAT[g]),
      .MAX_PKT_LEN(MAXL[g])
    ) u_dut (
      .aclk(aclk),
      .areset(areset),
      .axis(bus),
      .clr_stats(clr),
      .beat_count(bc[g]),
      .pkt_count(pc[g]),
      .last_pkt_len(ll[g]),
      .data_err(de[g]),
      .len_err(le[g]),
      .proto_err(pe[g]),
      .err_count(ec[g]),
      .busy(bz[g])
    );
  end

  function automatic snap_t get_snap(input int sel);
    get_snap = '{beats: bc[sel], pkts: pc[sel], last: ll[sel], derr: de[sel], lerr: le[sel],
                 perr: pe[sel], errc: ec[sel], busy: bz[sel]};
  endfunction

  function automatic snap_t model_snap();
    model_snap = '{beats: m_beats, pkts: m_pkts, last: m_last, derr: m_derr, lerr: m_lerr,
                   perr: 1'b0, errc: m_errc, busy: m_busy};
  endfunction

  task automatic model_reset();
    m_beats = '0; m_pkts = '0; m_last = '0; m_derr = 1'b0; m_lerr = 1'b0;
    m_errc = '0; m_busy = 1'b0; m_hit = 1'b0; m_exp = '0; m_plen = 0;
  endtask

  task automatic model_step(input int sel, input logic hs);
    logic ev;
    ev = 1'b0;
    if (clr) begin
      m_beats = '0; m_pkts = '0; m_last = '0; m_derr = 1'b0; m_lerr = 1'b0; m_errc = '0;
    end
    if (hs) begin
      m_beats = m_beats + 1;
      if (td !== m_exp) begin m_derr = 1'b1; ev = 1'b1; end
      m_exp = td + 1;
      if ((m_plen + 1 > MAXL[sel]) && !m_hit) begin m_lerr = 1'b1; m_hit = 1'b1; ev = 1'b1; end
      if (tl) begin
        m_pkts = m_pkts + 1;
        m_last = (m_plen >= 65535) ? 16'hFFFF : 16'(m_plen + 1);
        m_plen = 0; m_hit = 1'b0; m_busy = 1'b0;
      end else begin
        if (m_plen < 65535) m_plen = m_plen + 1;
        m_busy = 1'b1;
      end
    end
    if (ev && m_errc != 8'hFF) m_errc = m_errc + 1;
  endtask

  // One clock: check tready against the rotated pattern, predict, then compare one cycle later.
  task automatic tick(input int sel, output logic hs);
    logic [15:0] p;
    logic        er;
    snap_t       e, a;
    p  = PAT[sel];
    er = (cyc == 0) ? 1'b0 : p[cyc % 16];
    n_chk++;
    if (rdy[sel] !== er) begin
      n_fail++;
      $display("FAIL tready inst%0d cyc%0d: got %b want %b", sel, cyc, rdy[sel], er);
    end
    hs = tv[sel] && rdy[sel];
    model_step(sel, hs);
    sb.push_back(model_snap());
    @(negedge aclk);
    clr = 1'b0;
    e = sb.pop_front();
    a = get_snap(sel);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL stats inst%0d cyc%0d: got %h want %h", sel, cyc, a, e);
    end
  endtask

  task automatic send_beat(input int sel, input logic [31:0] d, input logic l);
    logic hs, ok;
    ok = 1'b0;
    td = d; tl = l; tv[sel] = 1'b1;
    for (int w = 0; w < 64 && !ok; w++) begin
      tick(sel, hs);
      if (hs) ok = 1'b1;
    end
    tv[sel] = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_timeout inst%0d data %0d: got none want accept", sel, d);
    end
  endtask

  task automatic idle(input int sel, input int n);
    logic hs;
    for (int i = 0; i < n; i++) tick(sel, hs);
  endtask

  task automatic do_reset();
    areset = 1'b1; clr = 1'b0; tl = 1'b0;
    for (int i = 0; i < 4; i++) tv[i] = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    snap_t a;
    areset = 1'b1; tv[0] = 1'b1; td = 32'd5;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      a = get_snap(i);
      n_chk++;
      if (rdy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_tready inst%0d: got %b want 0", i, rdy[i]); end
      n_chk++;
      if (a !== '0) begin n_fail++; $display("FAIL reset_stats inst%0d: got %h want 0", i, a); end
    end
    tv[0] = 1'b0;
    do_reset();
  endtask

  task automatic test_packets();
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++) send_beat(0, 32'(p * 8 + b), b == 7);
    idle(0, 2);
    chk("pkts_beat_count", bc[0], 32);
    chk("pkts_pkt_count", 32'(pc[0]), 4);
    chk("pkts_last_len", 32'(ll[0]), 8);
    chk("pkts_err_count", 32'(ec[0]), 0);
    chk("pkts_busy", 32'(bz[0]), 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int b = 0; b < 16; b++) send_beat(1, 32'(b), b == 15);
    idle(1, 2);
    chk("bp_beat_count", bc[1], 16);
    chk("bp_data_err", 32'(de[1]), 0);
    chk("bp_last_len", 32'(ll[1]), 16);
  endtask

  task automatic test_data_err();
    logic [31:0] seq [5];
    seq = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd8};
    do_reset();
    for (int b = 0; b < 5; b++) send_beat(0, seq[b], b == 4);
    idle(0, 1);
    chk("derr_flag", 32'(de[0]), 1);
    chk("derr_err_count", 32'(ec[0]), 1);
    chk("derr_pkt_count", 32'(pc[0]), 1);
  endtask

  task automatic test_len_err();
    do_reset();
    for (int b = 0; b < 6; b++) send_beat(2, 32'(b), b == 5);
    idle(2, 1);
    chk("len_flag", 32'(le[2]), 1);
    chk("len_err_count", 32'(ec[2]), 1);
    chk("len_last_len", 32'(ll[2]), 6);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int b = 0; b < 3; b++) send_beat(0, 32'(b), 1'b0);
    do_reset();
    send_beat(0, 32'd0, 1'b0);
    send_beat(0, 32'd1, 1'b1);
    idle(0, 1);
    chk("rst_len_err", 32'(le[0]), 0);
    chk("rst_data_err", 32'(de[0]), 0);
    chk("rst_pkt_count", 32'(pc[0]), 1);
    chk("rst_last_len", 32'(ll[0]), 2);
  endtask

  task automatic test_clr_stats();
    do_reset();
    for (int b = 0; b < 3; b++) send_beat(0, 32'(b), b == 2);
    send_beat(0, 32'd9, 1'b0);
    clr = 1'b1;
    send_beat(0, 32'd10, 1'b1);
    chk("clr_hs_beat_count", bc[0], 1);
    chk("clr_hs_last_len", 32'(ll[0]), 2);
    clr = 1'b1;
    idle(0, 1);
    chk("clr_only_beat_count", bc[0], 0);
    clr = 1'b1;
    send_beat(0, 32'd0, 1'b1);
    chk("clr_err_data_err", 32'(de[0]), 1);
    chk("clr_err_err_count", 32'(ec[0]), 1);
  endtask

  task automatic test_proto();
    logic       found;
    logic       exp_p;
    logic [7:0] exp_e;
    do_reset();
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      if (rdy[3] === 1'b0) found = 1'b1;
      else @(negedge aclk);
    end
    chk("proto_stall_found", 32'(found), 1);
    td = 32'd0; tl = 1'b0; tv[3] = 1'b1;
    @(negedge aclk);
    tv[3] = 1'b0;
    repeat (2) @(negedge aclk);
`ifdef AXIS_SINK_PROTO_CHECK_EN
    exp_p = 1'b1; exp_e = 8'd1;
`else
    exp_p = 1'b0; exp_e = 8'd0;
`endif
    chk("proto_flag", 32'(pe[3]), 32'(exp_p));
    chk("proto_err_count", 32'(ec[3]), 32'(exp_e));
    chk("proto_beat_count", bc[3], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge aclk);
    test_reset();
    test_packets();
    test_backpressure();
    test_data_err();
    test_len_err();
    test_reset_mid_packet();
    test_clr_stats();
    test_proto();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_sink_checker.md
AXIS_SINK_CHECKER -- requirements
Module: axis_sink_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter READY_PATTERN, default 16'hFFFF, per-cycle tready mask rotated to apply backpressure.
REQ-003 SHALL have parameter MAX_PKT_LEN, default 256, maximum legal beats per packet (1..65535).
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 tvalid  in  1  upstream beat valid.
REQ-008 tready  out  1  sink ready (registered).
REQ-009 tdata  in  DATA_W  beat payload.
REQ-010 tstrb, tkeep  in  DATA_W/8 each  accepted, ignored.
REQ-011 tlast  in  1  final beat of packet.
REQ-012 tid, tdest, tuser  in  1 each  accepted, ignored.
REQ-013 clr_stats  in  1  single-cycle pulse clearing counters and sticky flags.
REQ-014 beat_count  out  32  accepted beats, wraps at 2^32.
REQ-015 pkt_count  out  16  completed packets (tlast beats), wraps at 2^16.
REQ-016 last_pkt_len  out  16  beat length of most recent completed packet.
REQ-017 data_err, len_err, proto_err  out  1 each  sticky error flags.
REQ-018 err_count  out  8  error-event cycles, saturates at 255.
REQ-019 busy  out  1  high while state is IN_PKT.

Function
REQ-020 Handshake SHALL be tvalid&&tready on a rising aclk edge; only handshaken beats update state or counters.
REQ-021 A 16-bit pattern register SHALL rotate right by one every non-reset cycle; tready SHALL equal its bit 0.
REQ-022 Expected-data register exp SHALL start at 0; on each handshake, tdata!=exp SHALL set data_err, and exp SHALL load tdata+1 (mod 2^DATA_W), resynchronising after a mismatch.
REQ-023 FSM states IDLE and IN_PKT: IDLE->IN_PKT on handshake with tlast=0; IN_PKT->IDLE on handshake with tlast=1; a single-beat packet (tlast on the first beat) SHALL remain in IDLE.
REQ-024 Per-packet beat counter SHALL count handshakes in the current packet, saturating at 16'hFFFF; on the tlast beat last_pkt_len SHALL load count+1 (saturated) and the counter SHALL clear.
REQ-025 len_err SHALL set on the handshake that makes the current packet length exceed MAX_PKT_LEN; an error event SHALL be counted at most once per packet.
REQ-026 err_count SHALL increment by exactly 1 in any cycle with at least one new error event, regardless of how many flags fire in that cycle.
REQ-027 Counter and flag updates SHALL appear on outputs one cycle after the handshake edge.
REQ-028 clr_stats SHALL zero beat_count, pkt_count, last_pkt_len, err_count and all sticky flags; an error or count event in the same cycle SHALL take precedence and be recorded post-clear. FSM and exp SHALL be unaffected by clr_stats.

Reset
REQ-029 While areset=1: tready=0, state=IDLE, exp=0, pattern=READY_PATTERN, and all counters, last_pkt_len, flags and busy SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet without setting len_err; the first beat after reset begins a new packet.

Configuration
REQ-031 With macro AXIS_SINK_PROTO_CHECK_EN defined: when tvalid=1 and tready=0 in cycle N, tvalid=0 or any change in tdata/tlast in cycle N+1 SHALL set proto_err and count one error event.
REQ-032 Without AXIS_SINK_PROTO_CHECK_EN: proto_err SHALL be tied 0 and no holding registers SHALL be synthesised.

Verification
REQ-033 READY_PATTERN=16'hFFFF; send 4 packets of 8 beats, data 0..31 -> beat_count=32, pkt_count=4, last_pkt_len=8, no errors, busy low at end.
REQ-034 READY_PATTERN=16'h5555; stream data 0..15, tlast on beat 15 -> tready alternates 0/1; all 16 beats accepted in order; data_err=0.
REQ-035 Data sequence 0,1,2,7,8 -> data_err=1 after beat 7, err_count=1, no further error on 8.
REQ-036 MAX_PKT_LEN=4; send a 6-beat packet -> len_err set on beat 5, err_count=1, last_pkt_len=6.
REQ-037 With AXIS_SINK_PROTO_CHECK_EN, READY_PATTERN=16'hFFFE; drop tvalid during the stall cycle -> proto_err=1; same stimulus without the macro -> proto_err=0.
REQ-038 Assert areset on beat 3 of a 10-beat packet, then send a 2-beat packet of data 0,1 -> no len_err or data_err, pkt_count=1, last_pkt_len=2.
